// File: rtl/adc_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : adc_cfg_seq
// Purpose  : Writes an ADC register table over SPI, triggers a transfer,
//            polls for completion and verifies the table by readback.
// Revision : 1.0
// ============================================================================
module adc_cfg_seq #(
    parameter int          NUM_REGS  = 4,
    parameter int          MAX_RETRY = 2,
    parameter logic [7:0]  POLL_MAX  = 8'd32,
    parameter logic [12:0] ADDR_XFER = 13'h0ff
) (
    input  logic                    clk_low_freq,
    input  logic                    RST,
    input  logic                    go_i,
    input  logic [13*NUM_REGS-1:0]  cfg_addr_i,
    input  logic [8*NUM_REGS-1:0]   cfg_data_i,
    output logic [12:0]             spi_addr_o,
    output logic [7:0]              spi_data_o,
    output logic                    spi_read_o,
    output logic                    spi_start_o,
    input  logic                    spi_busy_i,
    input  logic                    spi_finish_i,
    input  logic [7:0]              spi_rdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [1:0]              err_code_o,
    output logic [3:0]              err_idx_o,
    output logic [1:0]              retry_cnt_o
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_WR_ISSUE = 4'd1;
    localparam logic [3:0] c_WR_WAIT  = 4'd2;
    localparam logic [3:0] c_XF_ISSUE = 4'd3;
    localparam logic [3:0] c_XF_WAIT  = 4'd4;
    localparam logic [3:0] c_PL_ISSUE = 4'd5;
    localparam logic [3:0] c_PL_WAIT  = 4'd6;
    localparam logic [3:0] c_RB_ISSUE = 4'd7;
    localparam logic [3:0] c_RB_WAIT  = 4'd8;
    localparam logic [3:0] c_DONE     = 4'd9;
    localparam logic [3:0] c_ERROR    = 4'd10;

    localparam logic [3:0] c_LAST_IDX = 4'(NUM_REGS - 1);

    logic [3:0]  r_state;
    logic [3:0]  r_idx;
    logic [7:0]  r_poll;
    logic [1:0]  r_retry;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [3:0]  r_err_idx;
    logic        r_mm_seen;

    logic [12:0] w_cur_addr;
    logic [7:0]  w_cur_data;
    logic        w_issue;
    logic        w_last;
    logic        w_poll_more;

    // Table lookup as a mux so the index never selects past the table
    always_comb begin
        w_cur_addr = 13'd0;
        w_cur_data = 8'd0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_idx == 4'(k)) begin
                w_cur_addr = cfg_addr_i[13*k +: 13];
                w_cur_data = cfg_data_i[8*k +: 8];
            end
        end
    end

    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_poll_more = ({1'b0, r_poll} + 9'd1) < {1'b0, POLL_MAX};
    assign w_issue     = (r_state == c_WR_ISSUE) || (r_state == c_XF_ISSUE) ||
                         (r_state == c_PL_ISSUE) || (r_state == c_RB_ISSUE);

    always_ff @(posedge clk_low_freq or negedge RST) begin
        if (!RST) begin
            r_state    <= c_IDLE;
            r_idx      <= 4'd0;
            r_poll     <= 8'd0;
            r_retry    <= 2'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_err_idx  <= 4'd0;
            r_mm_seen  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE, c_ERROR: begin
                    if (go_i) begin
                        r_state    <= c_WR_ISSUE;
                        r_idx      <= 4'd0;
                        r_poll     <= 8'd0;
                        r_retry    <= 2'd0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'd0;
                        r_err_idx  <= 4'd0;
                        r_mm_seen  <= 1'b0;
                    end
                end
                c_WR_ISSUE: if (!spi_busy_i) r_state <= c_WR_WAIT;
                c_XF_ISSUE: if (!spi_busy_i) r_state <= c_XF_WAIT;
                c_PL_ISSUE: if (!spi_busy_i) r_state <= c_PL_WAIT;
                c_RB_ISSUE: if (!spi_busy_i) r_state <= c_RB_WAIT;
                c_WR_WAIT: begin
                    if (spi_finish_i) begin
                        if (w_last) begin
                            r_state <= c_XF_ISSUE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= c_WR_ISSUE;
                        end
                    end
                end
                c_XF_WAIT: begin
                    if (spi_finish_i) begin
                        r_poll  <= 8'd0;
                        r_state <= c_PL_ISSUE;
                    end
                end
                c_PL_WAIT: begin
                    if (spi_finish_i) begin
                        if (!spi_rdata_i[0]) begin
                            r_idx   <= 4'd0;
                            r_state <= c_RB_ISSUE;
                        end else if (w_poll_more) begin
                            r_poll  <= r_poll + 8'd1;
                            r_state <= c_PL_ISSUE;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                            r_state    <= c_ERROR;
                        end
                    end
                end
                c_RB_WAIT: begin
                    if (spi_finish_i) begin
                        if (spi_rdata_i == w_cur_data) begin
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= c_DONE;
                            end else begin
                                r_idx   <= r_idx + 4'd1;
                                r_state <= c_RB_ISSUE;
                            end
                        end else begin
                            // Keep the index of the first mismatch across retries
                            if (!r_mm_seen) begin
                                r_err_idx <= r_idx;
                                r_mm_seen <= 1'b1;
                            end
                            if (int'(r_retry) < MAX_RETRY) begin
                                r_retry <= r_retry + 2'd1;
                                r_idx   <= 4'd0;
                                r_state <= c_WR_ISSUE;
                            end else begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'd1;
                                r_state    <= c_ERROR;
                            end
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Transaction fields decode from state, so they hold until the WAIT exits
    always_comb begin
        spi_addr_o = 13'd0;
        spi_data_o = 8'd0;
        spi_read_o = 1'b0;
        case (r_state)
            c_WR_ISSUE, c_WR_WAIT: begin
                spi_addr_o = w_cur_addr;
                spi_data_o = w_cur_data;
            end
            c_XF_ISSUE, c_XF_WAIT: begin
                spi_addr_o = ADDR_XFER;
                spi_data_o = 8'h01;
            end
            c_PL_ISSUE, c_PL_WAIT: begin
                spi_addr_o = ADDR_XFER;
                spi_read_o = 1'b1;
            end
            c_RB_ISSUE, c_RB_WAIT: begin
                spi_addr_o = w_cur_addr;
                spi_read_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign spi_start_o = w_issue && !spi_busy_i;
    assign busy_o      = (r_state != c_IDLE) && (r_state != c_DONE) && (r_state != c_ERROR);
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;
    assign err_idx_o   = r_err_idx;
    assign retry_cnt_o = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_adc_cfg_seq.sv
`default_nettype none
// Directed testbench for adc_cfg_seq with a behavioural SPI slave model.
module tb_adc_cfg_seq;

    logic        clk_low_freq = 1'b0;
    logic        RST = 1'b0;
    logic        go_i = 1'b0;
    logic [25:0] cfg_addr_i = {13'h00d, 13'h014};
    logic [15:0] cfg_data_i = {8'h04, 8'h01};
    logic [12:0] spi_addr_o;
    logic [7:0]  spi_data_o;
    logic        spi_read_o;
    logic        spi_start_o;
    logic        spi_busy_i = 1'b0;
    logic        spi_finish_i = 1'b0;
    logic [7:0]  spi_rdata_i = 8'd0;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [3:0]  err_idx_o;
    logic [1:0]  retry_cnt_o;

    adc_cfg_seq #(
        .NUM_REGS  (2),
        .MAX_RETRY (2),
        .POLL_MAX  (8'd32),
        .ADDR_XFER (13'h0ff)
    ) dut (
        .clk_low_freq (clk_low_freq),
        .RST          (RST),
        .go_i         (go_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .spi_addr_o   (spi_addr_o),
        .spi_data_o   (spi_data_o),
        .spi_read_o   (spi_read_o),
        .spi_start_o  (spi_start_o),
        .spi_busy_i   (spi_busy_i),
        .spi_finish_i (spi_finish_i),
        .spi_rdata_i  (spi_rdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .err_idx_o    (err_idx_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    always #5 clk_low_freq = ~clk_low_freq;

    // Controls set by the stimulus block
    int poll_ones = 0;
    bit stuck = 1'b0;
    int corrupt_mode = 0;      // 0 none, 1 always, 2 only during pass n_xf==corrupt_pass
    int corrupt_pass = 0;

    // SPI slave model state and transaction log
    logic [7:0]  mem [0:8191];
    logic [12:0] log_addr [0:255];
    logic [7:0]  log_data [0:255];
    logic        log_read [0:255];
    int          n_tx = 0;
    int          n_xf = 0;
    int          polls_since_xf = 0;
    int          m_cnt = 0;
    logic [12:0] m_addr = 13'd0;
    logic        m_read = 1'b0;

    always @(posedge clk_low_freq) begin
        spi_finish_i <= 1'b0;
        if (spi_start_o && !spi_busy_i) begin
            log_addr[n_tx] <= spi_addr_o;
            log_data[n_tx] <= spi_data_o;
            log_read[n_tx] <= spi_read_o;
            n_tx    <= n_tx + 1;
            m_addr  <= spi_addr_o;
            m_read  <= spi_read_o;
            m_cnt   <= 2;
            spi_busy_i <= 1'b1;
            if (!spi_read_o) mem[spi_addr_o] <= spi_data_o;
            if (!spi_read_o && spi_addr_o == 13'h0ff) begin
                n_xf <= n_xf + 1;
                polls_since_xf <= 0;
            end
        end else if (spi_busy_i) begin
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end else begin
                spi_busy_i   <= 1'b0;
                spi_finish_i <= 1'b1;
                if (m_read && m_addr == 13'h0ff) begin
                    spi_rdata_i <= (stuck || polls_since_xf < poll_ones) ? 8'h01 : 8'h00;
                    polls_since_xf <= polls_since_xf + 1;
                end else if (m_read) begin
                    if (m_addr == 13'h00d &&
                        (corrupt_mode == 1 || (corrupt_mode == 2 && n_xf == corrupt_pass)))
                        spi_rdata_i <= mem[m_addr] ^ 8'h80;
                    else
                        spi_rdata_i <= mem[m_addr];
                end else begin
                    spi_rdata_i <= 8'h00;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_tx(input string tag, input int i, input logic [12:0] a,
                            input logic [7:0] d, input logic rd);
        check({tag, "_addr"}, 32'(log_addr[i]), 32'(a));
        check({tag, "_read"}, 32'(log_read[i]), 32'(rd));
        if (!rd) check({tag, "_data"}, 32'(log_data[i]), 32'(d));
    endtask

    task automatic pulse_go();
        @(negedge clk_low_freq) go_i = 1'b1;
        @(negedge clk_low_freq) go_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy_o && t < 3000) begin
            @(negedge clk_low_freq);
            t++;
        end
        check({tag, "_timeout"}, 32'(busy_o), 32'd0);
    endtask

    int base;
    int cnt;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_low_freq);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_start", 32'(spi_start_o), 0);
        check("rst_outs", {done_o, err_o, err_code_o, err_idx_o, retry_cnt_o}, 0);
        check("rst_addr", 32'(spi_addr_o), 0);
        RST = 1'b1;
        repeat (3) @(negedge clk_low_freq);
        check("idle_no_start", 32'(n_tx), 0);

        // Nominal run, with a go pulse injected while the first write is in flight
        base = n_tx;
        pulse_go();
        check("run_busy", 32'(busy_o), 1);
        cnt = 0;
        while (n_tx < base + 1 && cnt < 100) begin
            @(negedge clk_low_freq);
            cnt++;
        end
        go_i = 1'b1;
        @(negedge clk_low_freq) go_i = 1'b0;
        wait_idle("nom");
        check("nom_ntx", 32'(n_tx - base), 6);
        check_tx("nom_w0", base + 0, 13'h014, 8'h01, 1'b0);
        check_tx("nom_w1", base + 1, 13'h00d, 8'h04, 1'b0);
        check_tx("nom_xf", base + 2, 13'h0ff, 8'h01, 1'b0);
        check_tx("nom_pl", base + 3, 13'h0ff, 8'h00, 1'b1);
        check_tx("nom_r0", base + 4, 13'h014, 8'h00, 1'b1);
        check_tx("nom_r1", base + 5, 13'h00d, 8'h00, 1'b1);
        check("nom_done", {30'd0, done_o, err_o}, 32'b10);
        check("nom_retry", 32'(retry_cnt_o), 0);

        // Transfer bit busy for three polls
        base = n_tx;
        poll_ones = 3;
        pulse_go();
        wait_idle("poll3");
        poll_ones = 0;
        cnt = 0;
        for (int i = base; i < n_tx; i++)
            if (log_read[i] && log_addr[i] == 13'h0ff) cnt++;
        check("poll3_polls", 32'(cnt), 4);
        check("poll3_ntx", 32'(n_tx - base), 9);
        check_tx("poll3_rb", base + 7, 13'h014, 8'h00, 1'b1);
        check("poll3_done", {30'd0, done_o, err_o}, 32'b10);

        // Transfer bit stuck: poll timeout
        base = n_tx;
        stuck = 1'b1;
        pulse_go();
        wait_idle("stuck");
        stuck = 1'b0;
        check("stuck_ntx", 32'(n_tx - base), 35);
        check("stuck_err", {29'd0, done_o, err_o, busy_o}, 32'b010);
        check("stuck_code", 32'(err_code_o), 2);

        // Entry 1 always reads back wrong
        base = n_tx;
        corrupt_mode = 1;
        pulse_go();
        wait_idle("mm");
        corrupt_mode = 0;
        cnt = 0;
        for (int i = base; i < n_tx; i++)
            if (!log_read[i] && log_addr[i] == 13'h014) cnt++;
        check("mm_passes", 32'(cnt), 3);
        check("mm_ntx", 32'(n_tx - base), 18);
        check("mm_err", {30'd0, done_o, err_o}, 32'b01);
        check("mm_code", 32'(err_code_o), 1);
        check("mm_idx", 32'(err_idx_o), 1);
        check("mm_retry", 32'(retry_cnt_o), 2);

        // Entry 1 wrong only on the first pass
        base = n_tx;
        corrupt_mode = 2;
        corrupt_pass = n_xf + 1;
        pulse_go();
        wait_idle("mm1");
        corrupt_mode = 0;
        check("mm1_ntx", 32'(n_tx - base), 12);
        check("mm1_done", {30'd0, done_o, err_o}, 32'b10);
        check("mm1_retry", 32'(retry_cnt_o), 1);
        check("mm1_code", 32'(err_code_o), 0);

        // Reset asserted while the first readback is in flight
        base = n_tx;
        pulse_go();
        cnt = 0;
        while (n_tx < base + 5 && cnt < 200) begin
            @(negedge clk_low_freq);
            cnt++;
        end
        check("rbw_reached", 32'(n_tx - base), 5);
        RST = 1'b0;
        #1;
        check("rbw_busy", 32'(busy_o), 0);
        check("rbw_start", 32'(spi_start_o), 0);
        check("rbw_addr", {spi_addr_o, spi_read_o}, 0);
        check("rbw_outs", {done_o, err_o, err_code_o, err_idx_o, retry_cnt_o}, 0);
        @(negedge clk_low_freq) RST = 1'b1;
        cnt = 0;
        while (spi_busy_i && cnt < 50) begin
            @(negedge clk_low_freq);
            cnt++;
        end
        repeat (5) @(negedge clk_low_freq);
        check("rbw_fin_ignored", 32'(busy_o), 0);
        check("rbw_no_tx", 32'(n_tx - base), 5);
        pulse_go();
        wait_idle("rbw_restart");
        check("rbw_ntx", 32'(n_tx - base), 11);
        check_tx("rbw_first", base + 5, 13'h014, 8'h01, 1'b0);
        check("rbw_done", {30'd0, done_o, err_o}, 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
